// File: rtl/tt_um_emern_poly_frontend_if.sv
// SPI pins of the polygon frontend, grouped so the host side and the
// frontend side can be connected as a single port.
interface tt_um_emern_poly_frontend_if;
    logic cs_in;
    logic mosi_in;
    logic sck_in;
    logic miso_out;

    modport master (output cs_in, output mosi_in, output sck_in, input miso_out);
    modport slave  (input cs_in, input mosi_in, input sck_in, output miso_out);
endinterface

// File: rtl/tt_um_emern_poly_frontend.sv
// SPI command frontend for the polygon GPU: captures fixed-length frames into
// shadow registers and copies them to the active outputs on a committed frame_sync.
//
// state    | meaning
// ST_IDLE  | cs high, counter and buffer held clear
// ST_SHIFT | cs low, collecting frame bits
// ST_FULL  | frame decoded, extra sck edges ignored until cs rises
module tt_um_emern_poly_frontend #(
    parameter int NUM_POLY = 4,
    parameter int X_W      = 7,
    parameter int Y_W      = 6,
    parameter int COLOR_W  = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    tt_um_emern_poly_frontend_if.slave   spi,
    input  logic                         en_load,
    input  logic                         frame_sync_in,
    output logic [COLOR_W-1:0]           bg_color_out,
    output logic [NUM_POLY*COLOR_W-1:0]  poly_color_out,
    output logic [NUM_POLY*X_W-1:0]      v0_x_out,
    output logic [NUM_POLY*X_W-1:0]      v1_x_out,
    output logic [NUM_POLY*X_W-1:0]      v2_x_out,
    output logic [NUM_POLY*Y_W-1:0]      v0_y_out,
    output logic [NUM_POLY*Y_W-1:0]      v1_y_out,
    output logic [NUM_POLY*Y_W-1:0]      v2_y_out,
    output logic [NUM_POLY-1:0]          poly_enable_out,
    output logic                         commit_pending_out,
    output logic [3:0]                   err_count_out
);
    localparam int FRAME_W = 8 + COLOR_W + 3*X_W + 3*Y_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int OFF_COL = 8;
    localparam int OFF_V0X = OFF_COL + COLOR_W;
    localparam int OFF_V1X = OFF_V0X + X_W;
    localparam int OFF_V2X = OFF_V1X + X_W;
    localparam int OFF_V0Y = OFF_V2X + X_W;
    localparam int OFF_V1Y = OFF_V0Y + Y_W;
    localparam int OFF_V2Y = OFF_V1Y + Y_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FULL} state_t;

    logic [1:0]         cs_sync_q, mosi_sync_q;
    logic [2:0]         sck_sync_q;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               pending_q, pending_d;
    logic [3:0]         err_q, err_d;
    logic               miso_q, miso_d;

    logic [COLOR_W-1:0] sh_col_q [NUM_POLY];
    logic [X_W-1:0]     sh_v0x_q [NUM_POLY];
    logic [X_W-1:0]     sh_v1x_q [NUM_POLY];
    logic [X_W-1:0]     sh_v2x_q [NUM_POLY];
    logic [Y_W-1:0]     sh_v0y_q [NUM_POLY];
    logic [Y_W-1:0]     sh_v1y_q [NUM_POLY];
    logic [Y_W-1:0]     sh_v2y_q [NUM_POLY];
    logic [NUM_POLY-1:0] sh_en_q;
    logic [COLOR_W-1:0]  sh_bg_q;

    logic [NUM_POLY*COLOR_W-1:0] act_col_q;
    logic [NUM_POLY*X_W-1:0]     act_v0x_q, act_v1x_q, act_v2x_q;
    logic [NUM_POLY*Y_W-1:0]     act_v0y_q, act_v1y_q, act_v2y_q;
    logic [NUM_POLY-1:0]         act_en_q;
    logic [COLOR_W-1:0]          act_bg_q;

    logic cs_s, mosi_s, sck_rise, accept, decode, short_frame;
    logic wr_poly, clr_poly, wr_bg, do_commit, bad_cmd, copy;
    logic [7:0] cmd, status;
    logic [5:0] idx;
    logic       idx_ok;

    assign cs_s     = cs_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];

    assign cmd    = frame_q[7:0];
    assign idx    = cmd[5:0];
    assign idx_ok = ({1'b0, idx} < 7'(NUM_POLY));
    assign status = {pending_q, 3'b000, err_q};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        accept      = 1'b0;
        short_frame = 1'b0;
        if (cs_s) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            frame_d     = '0;
            short_frame = (state_q == ST_SHIFT) && (bit_cnt_q != '0) && (bit_cnt_q < CNT_FULL);
        end else begin
            accept = sck_rise && en_load && (bit_cnt_q < CNT_FULL);
            if (accept) begin
                frame_d[bit_cnt_q] = mosi_s;
                bit_cnt_d          = bit_cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_IDLE:  state_d = ST_SHIFT;
                ST_SHIFT: if (bit_cnt_q == CNT_FULL) state_d = ST_FULL;
                ST_FULL:  state_d = ST_FULL;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Decode is tied to the SHIFT->FULL step so it fires exactly once per frame.
    assign decode    = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_FULL);
    assign wr_poly   = decode && (cmd[7:6] == 2'b10) && idx_ok;
    assign clr_poly  = decode && (cmd[7:6] == 2'b01) && idx_ok;
    assign wr_bg     = decode && (cmd == 8'h01);
    assign do_commit = decode && (cmd == 8'h02);
    assign bad_cmd   = decode && !(wr_poly || clr_poly || wr_bg || do_commit);
    assign copy      = frame_sync_in && pending_q;

    always_comb begin
        pending_d = pending_q;
        if (do_commit)
            pending_d = 1'b1;
        else if (copy)
            pending_d = 1'b0;
        err_d = err_q;
        if ((bad_cmd || short_frame) && (err_q != 4'hF))
            err_d = err_q + 4'd1;
        miso_d = 1'b0;
        if (!cs_s && (bit_cnt_d < CNT_W'(8)))
            miso_d = status[bit_cnt_d[2:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_sync_q  <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            pending_q   <= 1'b0;
            err_q       <= '0;
            miso_q      <= 1'b0;
            sh_en_q     <= '0;
            sh_bg_q     <= '0;
            for (int i = 0; i < NUM_POLY; i++) begin
                sh_col_q[i] <= '0;
                sh_v0x_q[i] <= '0;
                sh_v1x_q[i] <= '0;
                sh_v2x_q[i] <= '0;
                sh_v0y_q[i] <= '0;
                sh_v1y_q[i] <= '0;
                sh_v2y_q[i] <= '0;
            end
            act_col_q <= '0;
            act_v0x_q <= '0;
            act_v1x_q <= '0;
            act_v2x_q <= '0;
            act_v0y_q <= '0;
            act_v1y_q <= '0;
            act_v2y_q <= '0;
            act_en_q  <= '0;
            act_bg_q  <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], spi.cs_in};
            mosi_sync_q <= {mosi_sync_q[0], spi.mosi_in};
            sck_sync_q  <= {sck_sync_q[1:0], spi.sck_in};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            miso_q      <= miso_d;

            for (int i = 0; i < NUM_POLY; i++) begin
                if (idx == 6'(i)) begin
                    if (wr_poly) begin
                        sh_col_q[i] <= frame_q[OFF_COL +: COLOR_W];
                        sh_v0x_q[i] <= frame_q[OFF_V0X +: X_W];
                        sh_v1x_q[i] <= frame_q[OFF_V1X +: X_W];
                        sh_v2x_q[i] <= frame_q[OFF_V2X +: X_W];
                        sh_v0y_q[i] <= frame_q[OFF_V0Y +: Y_W];
                        sh_v1y_q[i] <= frame_q[OFF_V1Y +: Y_W];
                        sh_v2y_q[i] <= frame_q[OFF_V2Y +: Y_W];
                        sh_en_q[i]  <= 1'b1;
                    end else if (clr_poly) begin
                        sh_col_q[i] <= '0;
                        sh_v0x_q[i] <= '0;
                        sh_v1x_q[i] <= '0;
                        sh_v2x_q[i] <= '0;
                        sh_v0y_q[i] <= '0;
                        sh_v1y_q[i] <= '0;
                        sh_v2y_q[i] <= '0;
                        sh_en_q[i]  <= 1'b0;
                    end
                end
            end
            if (wr_bg)
                sh_bg_q <= frame_q[OFF_COL +: COLOR_W];

            // Non-blocking reads here give the pre-write shadow on a same-cycle write.
            if (copy) begin
                act_bg_q <= sh_bg_q;
                act_en_q <= sh_en_q;
                for (int i = 0; i < NUM_POLY; i++) begin
                    act_col_q[i*COLOR_W +: COLOR_W] <= sh_col_q[i];
                    act_v0x_q[i*X_W +: X_W]         <= sh_v0x_q[i];
                    act_v1x_q[i*X_W +: X_W]         <= sh_v1x_q[i];
                    act_v2x_q[i*X_W +: X_W]         <= sh_v2x_q[i];
                    act_v0y_q[i*Y_W +: Y_W]         <= sh_v0y_q[i];
                    act_v1y_q[i*Y_W +: Y_W]         <= sh_v1y_q[i];
                    act_v2y_q[i*Y_W +: Y_W]         <= sh_v2y_q[i];
                end
            end
        end
    end

    assign spi.miso_out        = miso_q;
    assign bg_color_out        = act_bg_q;
    assign poly_color_out      = act_col_q;
    assign v0_x_out            = act_v0x_q;
    assign v1_x_out            = act_v1x_q;
    assign v2_x_out            = act_v2x_q;
    assign v0_y_out            = act_v0y_q;
    assign v1_y_out            = act_v1y_q;
    assign v2_y_out            = act_v2y_q;
    assign poly_enable_out     = act_en_q;
    assign commit_pending_out  = pending_q;
    assign err_count_out       = err_q;
endmodule

// File: doc/tt_um_emern_poly_frontend.md
Name: tt_um_emern_poly_frontend

Overview:
Parametrised SPI command frontend for the polygon GPU. It receives fixed-length SPI frames and stores N polygons plus a background colour in shadow registers. Shadow state is copied to the active output registers only at a frame boundary, after an explicit COMMIT command. It feeds the rasteriser with packed per-polygon vertex and colour buses, counts malformed frames, and reports status over MISO.

Parameters:
NUM_POLY, 4, number of polygon slots (1..64)
X_W, 7, vertex x coordinate width
Y_W, 6, vertex y coordinate width
COLOR_W, 6, colour width for polygons and background
(derived) FRAME_W = 8 + COLOR_W + 3*X_W + 3*Y_W; the default is 53

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cs_in  in  1  SPI chip select, active low, asynchronous to clk
mosi_in  in  1  SPI data in
sck_in  in  1  SPI clock, mode 0
miso_out  out  1  SPI status out
en_load  in  1  SCK edges are accepted only while high (hsync/blank window)
frame_sync_in  in  1  one-cycle pulse at start of vertical blank
bg_color_out  out  COLOR_W  active background colour
poly_color_out  out  NUM_POLY*COLOR_W  active colours; polygon i at [i*COLOR_W +: COLOR_W]
v0_x_out, v1_x_out, v2_x_out  out  NUM_POLY*X_W  active vertex x, packed the same way
v0_y_out, v1_y_out, v2_y_out  out  NUM_POLY*Y_W  active vertex y, packed the same way
poly_enable_out  out  NUM_POLY  active per-polygon enable
commit_pending_out  out  1  COMMIT received, waiting for frame_sync_in
err_count_out  out  4  saturating malformed-frame counter

Behaviour:
- Reset: rst_n is asynchronous and active-low. All registers clear to 0: shadow, active, sync flops, counters, commit_pending, err_count. miso_out=0. Reset mid-frame discards the partial frame.
- Input sync: cs_in, mosi_in and sck_in each pass through a 2-flop synchroniser. A third sck flop detects the rising edge.
- Frame capture: while the synchronised cs is high, bit_cnt=0 and the buffer is cleared. While cs is low, each sck rise with en_load=1 and bit_cnt<FRAME_W stores mosi at buffer bit bit_cnt and increments bit_cnt. Sck rises with en_load=0 are ignored and do not count.
- Bit order: received bit k is frame bit k, so each field is LSB first.
- Frame layout, from bit 0 upward: cmd[7:0], color, v0_x, v1_x, v2_x, v0_y, v1_y, v2_y.
- Extra edges: once bit_cnt reaches FRAME_W, further sck edges are ignored until cs rises.
- Decode pulse: a one-cycle decode pulse fires on the clk edge after bit_cnt reaches FRAME_W. It fires exactly once per frame, and the shadow update happens on that edge.
- Commands:
  - 0x80|i (i<NUM_POLY): write shadow polygon i and set shadow enable[i].
  - 0x40|i (i<NUM_POLY): zero shadow polygon i and clear shadow enable[i].
  - 0x01: shadow bg = colour field.
  - 0x02: set commit_pending.
  - Any other value, or i>=NUM_POLY: no state change, err_count += 1.
- Short frame: cs rising while 0<bit_cnt<FRAME_W gives err_count += 1 and the frame is discarded.
- err_count saturates at 15 and is cleared only by reset.
- Commit: on frame_sync_in=1 with commit_pending=1, all shadow state (polygons, enables, bg) is copied to active on that edge and commit_pending clears.
- frame_sync_in with commit_pending=0 has no effect.
- Same-cycle COMMIT and frame_sync_in: pending is set; the copy waits for the next frame_sync_in.
- Write and copy on the same cycle: the copy takes the pre-write shadow value. The new write lands in shadow only.
- Active outputs are register outputs and change only at a commit copy.
- MISO: during frame bits 0..7 it drives status byte bit bit_cnt, where status = {commit_pending, 3'b0, err_count}. The value updates one clk after each accepted sck rise, so it is valid before the next rising edge. After bit 7, and while cs is high, miso_out=0.

Test Plan:
- Send 0x80 frame, colour 0x2A, v0=(10,5), v1=(100,20), v2=(50,60), no commit -> active outputs stay 0, commit_pending=0. Then 0x02, then frame_sync_in pulse -> poly_color_out[5:0]=0x2A, v1_x slot0=100, poly_enable_out=4'b0001, commit_pending 1->0 on that edge.
- Send 0x83 to slot 3 and 0x01 bg=0x15, commit, frame_sync -> slot 3 fields at offsets 3*W, bg_color_out=0x15, enables=4'b1001. Then 0x40, commit, frame_sync -> slot 0 zero, enables=4'b1000.
- COMMIT decode on the same cycle as frame_sync_in -> outputs unchanged, commit_pending=1. Next frame_sync -> copy occurs.
- NUM_POLY=4: send 0x85, then 0xC0, then a 20-bit frame with cs raised early -> err_count_out=3, shadow unchanged. Send 20 bad frames -> err_count_out=15.
- Toggle sck with en_load=0 for 30 edges mid-frame, then complete the frame with en_load=1 -> frame decodes correctly. 10 extra sck edges after bit 52 -> no second decode.
- Assert rst_n low asynchronously mid-frame after a pending commit -> all outputs 0, commit_pending=0, next full frame decodes normally.
